interconn_key_rx: RTL
=====================

// Module: interconn_key_rx
// PURPOSE
//  Z7-side receiver for the 6 game-control lines driven by the S7 slave board (Interconn2..7).
//  - Synchronises and debounces each line.
//  - Produces held levels plus 1-cycle press/release pulses.
//  - Latches short taps so a press shorter than one frame is never lost.
//  - Game logic samples a frame snapshot on frame_tick.
// PARAMETERS
//  N_KEYS           6       number of control lines; bit order per touhou_key_pkg
//  DEBOUNCE_CYCLES  100000  consecutive differing cycles required to accept a change (1 ms @100 MHz); must be >=1
// PORTS
//  sys_clk          in   1       system clock, 100 MHz
//  reset_rtl_0      in   1       asynchronous, active-low reset
//  key_lines_in     in   N_KEYS  raw lines from the board interconnect; asynchronous to sys_clk
//  frame_tick       in   1       1-cycle strobe per game frame; requests a snapshot
//  keys_held        out  N_KEYS  debounced level, 1 = pressed
//  key_press        out  N_KEYS  1-cycle pulse when keys_held bit rises
//  key_release      out  N_KEYS  1-cycle pulse when keys_held bit falls
//  frame_keys       out  N_KEYS  snapshot: keys held or tapped since the previous frame_tick
//  frame_valid      out  1       1-cycle pulse, asserted the cycle after frame_tick; frame_keys valid from then until next update
// BEHAVIOUR
//  Reset (async assert, sync release): all flops and outputs = 0, including synchronisers, counters,
//    keys_held, pulses, tap latch, frame_keys and frame_valid.
//    Reset mid-debounce discards the partial count.
//  Sync: 2-flop synchroniser per bit; the raw input is used nowhere else.
//  Debounce, per bit, with s = synchronised bit and h = keys_held bit:
//    - s == h: cnt <= 0.
//    - s != h and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//    - s != h and cnt == DEBOUNCE_CYCLES-1: h <= s, cnt <= 0, and pulse key_press (s=1) or key_release (s=0)
//      in the same cycle h updates.
//    - A glitch shorter than DEBOUNCE_CYCLES cycles never changes h.
//    - Counter width = $clog2(DEBOUNCE_CYCLES+1), minimum 1. No wrap is possible.
//  Latency: input edge to keys_held change = 2 sync cycles + DEBOUNCE_CYCLES cycles.
//  Pulses: registered outputs; never high for 2 consecutive cycles on the same bit.
//    key_press and key_release are mutually exclusive per bit.
//  Tap latch tap[i]: set on key_press[i]; cleared only by frame_tick.
//  Frame handshake, on frame_tick:
//    - frame_keys <= keys_held | tap | key_press (current-cycle values).
//    - tap <= 0.
//    - frame_valid <= 1 for the next cycle.
//  Simultaneous frame_tick and key_press[i]:
//    - The press is included in this snapshot.
//    - tap[i] is cleared.
//    - The still-held key appears again in the next snapshot via keys_held.
//  Back-to-back frame_tick is legal; each tick yields exactly one frame_valid pulse.
//  Press and release both inside one frame: frame_keys bit = 1 for that frame, 0 the frame after.
// STRUCTURE
//  Package touhou_key_pkg holds:
//    - localparam N_TOUHOU_KEYS = 6.
//    - Bit indices KEY_Z=0, KEY_SHIFT=1, KEY_UP=2, KEY_DOWN=3, KEY_LEFT=4, KEY_RIGHT=5;
//      this order is shared with the slave-side encoder.
//  Sub-module key_debounce (one bit: synchroniser + counter + held + press/release).
//    Instantiated N_KEYS times by generate.
//  Top level adds the tap latch and frame snapshot logic.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Hold key_lines_in=6'b000001 steady
//     -> keys_held[0] rises exactly 6 cycles after the input edge; key_press[0] high 1 cycle; all other bits 0.
//  2. 3-cycle glitch on bit 2 (0->1->0)
//     -> keys_held, key_press and key_release stay 0 on every bit.
//  3. Tap bit 5 for 8 cycles, release, then frame_tick 20 cycles later
//     -> frame_keys=6'b100000 and frame_valid pulses 1 cycle;
//        next frame_tick gives frame_keys=0.
//  4. frame_tick in the same cycle as key_press[1]
//     -> frame_keys[1]=1 and tap cleared;
//        key still held, so next frame_tick gives frame_keys[1]=1.
//  5. Assert reset_rtl_0=0 mid-count (cnt=2) with keys_held=6'b000011
//     -> all outputs 0 immediately without a clock edge;
//        after release, a steady input needs the full 6 cycles again.
//  6. All 6 lines toggle together at 1 and then release 10 cycles later
//     -> key_press=6'b111111 for one cycle; key_release=6'b111111 for one cycle;
//        pulses never overlap on the same bit.

Source files
------------

// File: rtl/touhou_key_pkg.sv
// Package: touhou_key_pkg
// Shared key-line definitions for the S7 -> Z7 game-control interconnect.
// The bit order below matches the slave-side encoder and must not change.
package touhou_key_pkg;

  localparam int unsigned N_TOUHOU_KEYS = 6;

  // Bit index of each control in key_lines_in / keys_held / frame_keys.
  typedef enum int unsigned {
    KEY_Z     = 0,
    KEY_SHIFT = 1,
    KEY_UP    = 2,
    KEY_DOWN  = 3,
    KEY_LEFT  = 4,
    KEY_RIGHT = 5
  } key_idx_e;

endpackage

// File: rtl/key_debounce.sv
// Module: key_debounce
// One control line: 2-flop synchroniser, debounce counter, held level and
// 1-cycle press/release pulses.
// Ports:
//   sys_clk      in   system clock
//   reset_rtl_0  in   asynchronous active-low reset
//   key_line_in  in   raw line, asynchronous to sys_clk
//   key_held     out  debounced level, 1 = pressed
//   key_press    out  1-cycle pulse on the cycle key_held rises
//   key_release  out  1-cycle pulse on the cycle key_held falls
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic sys_clk,
  input  logic reset_rtl_0,
  input  logic key_line_in,
  output logic key_held,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             expire;

  always_comb begin
    differ = (sync_q2 != key_held);
    expire = differ && (cnt == CNT_LAST);
  end

  always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      cnt         <= '0;
      key_held    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q1     <= key_line_in;
      sync_q2     <= sync_q1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (expire) begin
        // Level and its edge pulse update together, so a pulse always
        // coincides with the first cycle of the new held level.
        key_held    <= sync_q2;
        key_press   <= sync_q2;
        key_release <= ~sync_q2;
        cnt         <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/interconn_key_rx.sv
// Module: interconn_key_rx
// Z7-side receiver for the game-control lines driven by the S7 slave board.
// Each line is synchronised and debounced; short taps are latched until the
// next frame so the game never misses a press shorter than a frame.
// Ports:
//   sys_clk      in   system clock, 100 MHz
//   reset_rtl_0  in   asynchronous active-low reset
//   key_lines_in in   raw lines from the board interconnect (asynchronous)
//   frame_tick   in   1-cycle strobe per game frame, requests a snapshot
//   keys_held    out  debounced levels, 1 = pressed
//   key_press    out  1-cycle pulse per bit when keys_held rises
//   key_release  out  1-cycle pulse per bit when keys_held falls
//   frame_keys   out  keys held or tapped since the previous frame_tick
//   frame_valid  out  1-cycle pulse the cycle after frame_tick
module interconn_key_rx
  import touhou_key_pkg::*;
#(
  parameter int unsigned N_KEYS          = N_TOUHOU_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic              sys_clk,
  input  logic              reset_rtl_0,
  input  logic [N_KEYS-1:0] key_lines_in,
  input  logic              frame_tick,
  output logic [N_KEYS-1:0] keys_held,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] frame_keys,
  output logic              frame_valid
);

  logic [N_KEYS-1:0] tap;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .sys_clk     (sys_clk),
      .reset_rtl_0 (reset_rtl_0),
      .key_line_in (key_lines_in[i]),
      .key_held    (keys_held[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

  always_ff @(posedge sys_clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      tap         <= '0;
      frame_keys  <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_tick;
      if (frame_tick) begin
        // A press arriving with the tick is folded into this snapshot
        // directly, so clearing tap here loses nothing.
        frame_keys <= keys_held | tap | key_press;
        tap        <= '0;
      end else begin
        tap <= tap | key_press;
      end
    end
  end

endmodule
